// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   - uart_state_t    : frame state encoding. The transmitter uses the same
//                       encoding, so keep the values fixed.
//   - UART_DATA_BITS  : default number of data bits per frame.
//   - UART_OVERSAMPLE : default number of baud ticks per bit period.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for asynchronous single-bit inputs. Each bit gets its
// own pair of flops. Both flops load RESET_VALUE while reset is high. The
// default reset value of 1 matches an idle-high serial line.
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   async_in in   [WIDTH] asynchronous inputs
//   sync_out out  [WIDTH] synchronized outputs, two clocks of latency
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int   WIDTH       = 1,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= RESET_VALUE;
                    sync_reg <= RESET_VALUE;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_out[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// UART serial receiver for frames with DATA_BITS data bits, no parity and one
// stop bit. Data bits arrive LSB first. All timing comes from the shared
// OVERSAMPLE x baud tick. The receiver samples the start bit, every data bit
// and the stop bit at the bit midpoint. The frame completes at the middle of
// the stop bit, so a start bit that follows the stop bit directly is still
// caught.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   baudTick  in   one-clock pulse at OVERSAMPLE x baud rate
//   rx        in   asynchronous serial line (idle high)
//   rx_data   out  [DATA_BITS] last received byte, held until the next frame
//   rx_done   out  one-clock pulse when rx_data updates
//   frame_err out  stop bit was sampled low; updated together with rx_done
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baudTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err
);

    localparam int S_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick counts at which the FSM samples the line. In START the count is
    // checked at half a bit, so later checks land on bit midpoints.
    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_reg, state_next;
    logic [S_W-1:0]       s_reg, s_next;
    logic [N_W-1:0]       n_reg, n_next;
    logic [DATA_BITS-1:0] b_reg, b_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_done_reg, rx_done_next;
    logic                 frame_err_reg, frame_err_next;

    uart_rx_sync #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (rx),
        .sync_out (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            n_reg         <= '0;
            b_reg         <= '0;
            rx_data_reg   <= '0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            n_reg         <= n_next;
            b_reg         <= b_next;
            rx_data_reg   <= rx_data_next;
            rx_done_reg   <= rx_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        s_next         = s_reg;
        n_next         = n_reg;
        b_next         = b_reg;
        rx_data_next   = rx_data_reg;
        frame_err_next = frame_err_reg;
        rx_done_next   = 1'b0;  // pulse: only the STOP completion sets it

        case (state_reg)
            IDLE: begin
                // Detect the falling edge as soon as it is seen. Waiting
                // for a tick here would add up to one tick of phase error.
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (baudTick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // The line is high again at mid start bit.
                            // Treat it as a glitch and drop it quietly.
                            state_next = IDLE;
                            s_next     = '0;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            DATA: begin
                if (baudTick) begin
                    if (s_reg == S_LAST) begin
                        // Data bits arrive LSB first. Shift in from the
                        // top so bit 0 ends up at b[0] after the last bit.
                        b_next = {rx_s, b_reg[DATA_BITS-1:1]};
                        s_next = '0;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            STOP: begin
                if (baudTick) begin
                    if (s_reg == S_LAST) begin
                        // Deliver the byte even when the stop bit is bad.
                        // The consumer decides what to do with frame_err.
                        rx_data_next   = b_reg;
                        frame_err_next = ~rx_s;
                        rx_done_next   = 1'b1;
                        state_next     = IDLE;
                        s_next         = '0;
                        n_next         = '0;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_done   = rx_done_reg;
    assign frame_err = frame_err_reg;

endmodule
